// File: rtl/mult_booth_param_pkg.sv
// Shared definitions for the HI/LO multi-cycle arithmetic units.
// State encodings and counter sizing are common to the multiplier and the divider.
package mult_booth_param_pkg;

    typedef enum logic [1:0] {
        MULT_IDLE   = 2'd0,
        MULT_RUN    = 2'd1,
        MULT_FINISH = 2'd2
    } mult_state_e;

    // The step counter must be able to hold WIDTH+1.
    function automatic int mult_cnt_w(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/mult_booth_param_booth_step.sv
// One radix-2 Booth step: conditional add of +/-M into A, then arithmetic shift of {A,Q,Q_1}.
module booth_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH+2:0] acc_in,
    input  logic [WIDTH:0]     m,
    input  logic [WIDTH:0]     neg_m,
    output logic [2*WIDTH+2:0] acc_out
);

    logic [WIDTH:0] a_cur;
    logic [WIDTH:0] a_sum;

    assign a_cur = acc_in[2*WIDTH+2 -: WIDTH+1];

    // acc_in[1:0] is {Q[0], Q_1}; sums wrap modulo 2^(WIDTH+1).
    always_comb begin
        a_sum = a_cur;
        case (acc_in[1:0])
            2'b10:   a_sum = a_cur + neg_m;
            2'b01:   a_sum = a_cur + m;
            default: a_sum = a_cur;
        endcase
    end

    assign acc_out = {a_sum[WIDTH], a_sum, acc_in[WIDTH+1:1]};

endmodule

// File: rtl/mult_booth_param.sv
// Multi-cycle radix-2 Booth multiplier (MULT/MULTU) with start/busy/done handshake.
// Operands are captured at the accepting edge; hi/lo hold the last completed product.
module mult_booth_param
    import mult_booth_param_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] value_a,
    input  logic [WIDTH-1:0] value_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = mult_cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH + 1);

    mult_state_e        state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH+2:0] acc;
    logic [WIDTH:0]     m;
    logic [WIDTH:0]     neg_m;
    logic [2*WIDTH+2:0] acc_next;
    logic [WIDTH:0]     ext_a;
    logic [WIDTH:0]     ext_b;

    // One extra bit lets unsigned all-ones operands be treated as positive Booth values.
    assign ext_a = {is_signed & value_a[WIDTH-1], value_a};
    assign ext_b = {is_signed & value_b[WIDTH-1], value_b};

    booth_step #(.WIDTH(WIDTH)) u_step (
        .acc_in  (acc),
        .m       (m),
        .neg_m   (neg_m),
        .acc_out (acc_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= MULT_IDLE;
            cnt   <= '0;
            acc   <= '0;
            m     <= '0;
            neg_m <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                MULT_IDLE: begin
                    if (start) begin
                        m     <= ext_a;
                        neg_m <= -ext_a;
                        acc   <= {{(WIDTH+1){1'b0}}, ext_b, 1'b0};
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= MULT_RUN;
                    end
                end
                MULT_RUN: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (cnt + 1'b1 == LAST_STEP)
                        state <= MULT_FINISH;
                end
                MULT_FINISH: begin
                    // Product is the low 2*WIDTH bits of {A,Q}.
                    hi    <= acc[2*WIDTH:WIDTH+1];
                    lo    <= acc[WIDTH:1];
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= MULT_IDLE;
                end
                default: state <= MULT_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_booth_param.sv
// Self-checking bench: directed WIDTH=32 cases plus random WIDTH=8 pairs against arithmetic reference.
module tb_mult_booth_param;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        start32, sgn32, busy32, done32;
    logic [31:0] a32, b32, hi32, lo32;
    logic        start8, sgn8, busy8, done8;
    logic [7:0]  a8, b8, hi8, lo8;

    int n_chk = 0;
    int n_err = 0;

    mult_booth_param #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .start(start32), .is_signed(sgn32),
        .value_a(a32), .value_b(b32), .busy(busy32), .done(done32), .hi(hi32), .lo(lo32)
    );

    mult_booth_param #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .is_signed(sgn8),
        .value_a(a8), .value_b(b8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref32(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [63:0] xa, xb;
        xa = s ? {{32{a[31]}}, a} : {32'b0, a};
        xb = s ? {{32{b[31]}}, b} : {32'b0, b};
        return xa * xb;
    endfunction

    function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
        int xa, xb, p;
        xa = s ? int'($signed(a)) : int'(a);
        xb = s ? int'($signed(b)) : int'(b);
        p  = xa * xb;
        return p[15:0];
    endfunction

    // Issues one WIDTH=32 op; with chaos=1, start stays high and inputs churn while busy.
    task automatic op32(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input bit chaos);
        int n, busy_cnt;
        bit stable;
        logic [31:0] hold_hi, hold_lo;
        logic [63:0] exp;
        exp = ref32(a, b, s);
        @(negedge clk);
        a32 = a; b32 = b; sgn32 = s; start32 = 1'b1;
        hold_hi = hi32; hold_lo = lo32;
        @(posedge clk);
        n = 0; busy_cnt = 0; stable = 1;
        forever begin
            @(negedge clk);
            if (busy32) busy_cnt++;
            if (done32) break;
            if (hi32 !== hold_hi || lo32 !== hold_lo) stable = 0;
            if (chaos) begin
                a32 = $urandom; b32 = $urandom; sgn32 = 1'($urandom);
            end else begin
                start32 = 1'b0;
            end
            if (n > 100) break;
            @(posedge clk);
            n++;
        end
        start32 = 1'b0;
        chk({tag, " latency"}, 64'(n), 64'd34);
        chk({tag, " product"}, {hi32, lo32}, exp);
        chk({tag, " busy_cycles"}, 64'(busy_cnt), 64'd34);
        chk({tag, " hilo_stable"}, 64'(stable), 64'd1);
        @(negedge clk);
        chk({tag, " done_pulse"}, 64'(done32), 64'd0);
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s);
        int n;
        @(negedge clk);
        a8 = a; b8 = b; sgn8 = s; start8 = 1'b1;
        @(posedge clk);
        n = 0;
        forever begin
            @(negedge clk);
            start8 = 1'b0;
            if (done8 || n > 40) break;
            @(posedge clk);
            n++;
        end
        chk("w8 latency", 64'(n), 64'd10);
        chk("w8 product", {48'b0, hi8, lo8}, {48'b0, ref8(a, b, s)});
    endtask

    initial begin
        int n;
        bit saw_done;
        reset = 1'b1;
        start32 = 0; sgn32 = 0; a32 = '0; b32 = '0;
        start8 = 0; sgn8 = 0; a8 = '0; b8 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset busy", 64'(busy32), 64'd0);
        chk("reset done", 64'(done32), 64'd0);
        chk("reset hilo", {hi32, lo32}, 64'd0);
        reset = 1'b0;

        op32("s7xm3", 32'd7, 32'hFFFF_FFFD, 1'b1, 0);
        chk("s7xm3 hi", 64'(hi32), 64'hFFFF_FFFF);
        chk("s7xm3 lo", 64'(lo32), 64'hFFFF_FFEB);
        op32("u_ff_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
        chk("u_ff_ff hilo", {hi32, lo32}, 64'hFFFF_FFFE_0000_0001);
        op32("s_ff_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0);
        chk("s_ff_ff hilo", {hi32, lo32}, 64'h0000_0000_0000_0001);
        op32("s_min_min", 32'h8000_0000, 32'h8000_0000, 1'b1, 0);
        chk("s_min_min hilo", {hi32, lo32}, 64'h4000_0000_0000_0000);
        op32("u_ff_x2", 32'hFFFF_FFFF, 32'd2, 1'b0, 0);
        chk("u_ff_x2 hilo", {hi32, lo32}, 64'h0000_0001_FFFF_FFFE);
        op32("chaos", 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1);
        op32("u_rand", $urandom, 32'hDEAD_BEEF, 1'b0, 0);

        // Reset ten cycles into RUN abandons the operation.
        @(negedge clk);
        a32 = 32'd99; b32 = 32'd77; sgn32 = 1'b0; start32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start32 = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset busy", 64'(busy32), 64'd0);
        chk("midreset done", 64'(done32), 64'd0);
        chk("midreset hilo", {hi32, lo32}, 64'd0);
        reset = 1'b0;
        saw_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done32 || busy32) saw_done = 1;
        end
        chk("midreset no_done", 64'(saw_done), 64'd0);

        // reset and start together: start is not accepted.
        @(negedge clk);
        reset = 1'b1; start32 = 1'b1; a32 = 32'd3; b32 = 32'd4;
        @(negedge clk);
        reset = 1'b0; start32 = 1'b0;
        chk("reset_vs_start busy", 64'(busy32), 64'd0);
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (done32) n++;
        end
        chk("reset_vs_start no_done", 64'(n), 64'd0);

        op32("u5x6", 32'd5, 32'd6, 1'b0, 0);
        chk("u5x6 hilo", {hi32, lo32}, 64'd30);

        op8(8'h80, 8'h80, 1'b1);
        op8(8'hFF, 8'hFF, 1'b0);
        op8(8'hFF, 8'h7F, 1'b1);
        for (int i = 0; i < 2000; i++)
            op8(8'($urandom), 8'($urandom), 1'($urandom));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
